dither_stream: RTL and testbench

// Streaming colour-depth reducer between the frame source and the VGA colour DAC path.

---
 rtl/dither_stream.sv | 190 +++++++++++++++++++
 tb/tb_dither_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_stream.sv
// Streaming colour-depth reducer: two-stage valid/ready pipeline that quantises each
// channel by truncation, rounding, 4x4 Bayer ordered dither or 1-D error diffusion.
module dither_stream #(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 4,
  parameter int CHANNELS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CHANNELS*IN_W-1:0]  s_data,
  input  logic                      s_sof,
  input  logic                      s_eol,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CHANNELS*OUT_W-1:0] m_data,
  output logic                      m_sof,
  output logic                      m_eol
);

  localparam int SH = IN_W - OUT_W;

  localparam logic [1:0] MODE_TRUNC = 2'd0;
  localparam logic [1:0] MODE_ROUND = 2'd1;
  localparam logic [1:0] MODE_BAYER = 2'd2;
  localparam logic [1:0] MODE_ERRDF = 2'd3;

  // Handshake: a beat moves on a port when valid && ready on the same rising edge.
  // A stage may load whenever it is empty or its content leaves in that same cycle,
  // so s_ready depends combinationally on m_ready.

  logic                      v1_q, v1_d;
  logic [CHANNELS*IN_W-1:0]  d1_q, d1_d;
  logic                      sof1_q, sof1_d, eol1_q, eol1_d;
  logic [1:0]                mode1_q, mode1_d;
  logic [1:0]                x1_q, x1_d, y1_q, y1_d;

  logic                      v2_q, v2_d;
  logic [CHANNELS*OUT_W-1:0] d2_q, d2_d;
  logic                      sof2_q, sof2_d, eol2_q, eol2_d;

  logic [1:0]                x_q, x_d, y_q, y_d;
  logic [CHANNELS*SH-1:0]    carry_q, carry_d;

  logic adv1, adv2, acc, xfer;

  logic [CHANNELS*OUT_W-1:0] q_all;
  logic [CHANNELS*SH-1:0]    carry_new;

  assign adv2    = !v2_q || m_ready;
  assign adv1    = !v1_q || adv2;
  assign s_ready = adv1;
  assign acc     = s_valid && adv1;
  assign xfer    = v1_q && adv2;

  assign m_valid = v2_q;
  assign m_data  = d2_q;
  assign m_sof   = sof2_q;
  assign m_eol   = eol2_q;

  function automatic logic [3:0] bayer(input logic [1:0] yy, input logic [1:0] xx);
    logic [3:0] t;
    case ({yy, xx})
      4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
      4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
      4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'hA: t = 4'd1;   4'hB: t = 4'd9;
      4'hC: t = 4'd15;  4'hD: t = 4'd7;   4'hE: t = 4'd13;  default: t = 4'd5;
    endcase
    return t;
  endfunction

  // Per-channel quantiser on the S1 contents; the stored carry is ignored for sof beats.
  always_comb begin
    logic [IN_W-1:0] in_c;
    logic [IN_W:0]   add;
    logic [IN_W:0]   sum;
    logic [IN_W-1:0] satv;
    logic [IN_W+4:0] tw;
    q_all     = '0;
    carry_new = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_c = d1_q[c*IN_W +: IN_W];
      add  = '0;
      tw   = '0;
      case (mode1_q)
        MODE_ROUND: add[SH-1] = 1'b1;
        MODE_BAYER: begin
          tw  = (IN_W+5)'(bayer(y1_q, x1_q)) << SH;
          add = tw[IN_W+4:4];
        end
        MODE_ERRDF: if (!sof1_q) add[SH-1:0] = carry_q[c*SH +: SH];
        default:    add = '0;
      endcase
      sum  = {1'b0, in_c} + add;
      satv = sum[IN_W] ? {IN_W{1'b1}} : sum[IN_W-1:0];
      q_all[c*OUT_W +: OUT_W] = satv[IN_W-1:SH];
      carry_new[c*SH +: SH]   = satv[SH-1:0];
    end
  end

  always_comb begin
    v1_d    = v1_q;
    d1_d    = d1_q;
    sof1_d  = sof1_q;
    eol1_d  = eol1_q;
    mode1_d = mode1_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x_d     = x_q;
    y_d     = y_q;
    v2_d    = v2_q;
    d2_d    = d2_q;
    sof2_d  = sof2_q;
    eol2_d  = eol2_q;
    carry_d = carry_q;

    if (acc) begin
      v1_d    = 1'b1;
      d1_d    = s_data;
      sof1_d  = s_sof;
      eol1_d  = s_eol;
      mode1_d = mode;
      x1_d    = s_sof ? 2'd0 : x_q;
      y1_d    = s_sof ? 2'd0 : y_q;
      if (s_sof && s_eol) begin
        x_d = 2'd0;
        y_d = 2'd1;
      end else if (s_sof) begin
        x_d = 2'd1;
        y_d = 2'd0;
      end else if (s_eol) begin
        x_d = 2'd0;
        y_d = y_q + 2'd1;
      end else begin
        x_d = x_q + 2'd1;
      end
    end else if (xfer) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        d2_d   = q_all;
        sof2_d = sof1_q;
        eol2_d = eol1_q;
        // Error is carried only along a line of diffusion beats.
        if (mode1_q == MODE_ERRDF && !eol1_q) carry_d = carry_new;
        else                                  carry_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      d1_q    <= '0;
      sof1_q  <= 1'b0;
      eol1_q  <= 1'b0;
      mode1_q <= MODE_TRUNC;
      x1_q    <= 2'd0;
      y1_q    <= 2'd0;
      x_q     <= 2'd0;
      y_q     <= 2'd0;
      v2_q    <= 1'b0;
      d2_q    <= '0;
      sof2_q  <= 1'b0;
      eol2_q  <= 1'b0;
      carry_q <= '0;
    end else begin
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      sof1_q  <= sof1_d;
      eol1_q  <= eol1_d;
      mode1_q <= mode1_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      v2_q    <= v2_d;
      d2_q    <= d2_d;
      sof2_q  <= sof2_d;
      eol2_q  <= eol2_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_dither_stream.sv
// Directed bench for dither_stream (IN_W=8, OUT_W=4, CHANNELS=3) with hand-computed vectors.
module tb_dither_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        s_eol;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_data;
  logic        m_sof;
  logic        m_eol;

  int checks = 0;
  int errors = 0;

  // Observed beats as {sof, eol, data}, and the expected queue.
  logic [13:0] out_q[$];
  logic [13:0] exp_q[$];

  dither_stream #(.IN_W(8), .OUT_W(4), .CHANNELS(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol)
  );

  always #5 clk = ~clk;

  // A beat seen valid && ready at the negedge transfers on the following posedge.
  always @(negedge clk)
    if (rst_n && m_valid && m_ready) out_q.push_back({m_sof, m_eol, m_data});

  task automatic push(input logic [23:0] d, input logic sof, input logic eol, input logic [1:0] md);
    logic acc;
    acc     = 1'b0;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    mode    = md;
    s_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: beat %h never accepted", d);
    end
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 100 && out_q.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 12'h000) begin errors++; $display("FAIL reset_m_data: got %h want 000", m_data); end
    checks++; if (m_sof !== 1'b0 || m_eol !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", m_sof, m_eol); end
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    // Fill both stages with a stalled sink, then reset mid-frame.
    m_ready = 1'b0;
    mode    = 2'd3;
    s_valid = 1'b1; s_data = 24'h080808; s_sof = 1'b1; s_eol = 1'b0;
    @(posedge clk); #1;
    s_data = 24'h121212; s_sof = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL full_pipe: m_valid %b s_ready %b want 1 0", m_valid, s_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midframe_reset_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 12'h000) begin errors++; $display("FAIL midframe_reset_data: got %h want 000", m_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
    out_q.delete();
    m_ready = 1'b1;
    @(posedge clk); #1;
    push(24'h808080, 1'b0, 1'b0, 2'd3);
    wait_out(1);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 14'h0888) begin
      errors++; $display("FAIL reset_first_beat: got %h (n=%0d) want 0888", (out_q.size() > 0) ? out_q[0] : 14'h0, out_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    logic acc;
    out_q.delete();
    m_ready = 1'b1;
    mode = 2'd0; s_data = 24'hABCDEF; s_sof = 1'b1; s_eol = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    acc = s_ready;
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL lat_accept: s_ready %b want 1", acc); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_early: m_valid %b want 0 one cycle after accept", m_valid); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: m_valid %b want 1 two cycles after accept", m_valid); end
    checks++; if (m_data !== 12'hACE) begin errors++; $display("FAIL trunc_data: got %h want ACE", m_data); end
    checks++; if (m_sof !== 1'b1 || m_eol !== 1'b1) begin errors++; $display("FAIL trunc_flags: got %b%b want 11", m_sof, m_eol); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_drain: m_valid %b want 0", m_valid); end
  endtask

  task automatic test_round();
    out_q.delete();
    push(24'h000017, 1'b1, 1'b0, 2'd1);
    push(24'h000018, 1'b0, 1'b0, 2'd1);
    push(24'h0000F8, 1'b0, 1'b1, 2'd1);
    wait_out(3);
    exp_q = '{14'h2001, 14'h0002, 14'h100F};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL round_%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 14'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_bayer();
    logic [15:0] hi_map;
    int          ones;
    // Bit (y*4+x) set where B[y][x] >= 8.
    hi_map = 16'b0101_1010_0101_1010;
    ones   = 0;
    out_q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        push(24'h080808, (x == 0 && y == 0), (x == 3), 2'd2);
    wait_out(16);
    for (int i = 0; i < 16; i++) begin
      logic [13:0] e;
      e = {(i == 0), (i % 4 == 3), (hi_map[i] ? 12'h111 : 12'h000)};
      checks++;
      if (i >= out_q.size() || out_q[i] !== e) begin
        errors++; $display("FAIL bayer_pix_%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 14'h0, e);
      end else if (out_q[i][11:0] == 12'h111) ones++;
    end
    checks++; if (ones != 8) begin errors++; $display("FAIL bayer_count: got %0d want 8", ones); end
  endtask

  task automatic test_diffusion();
    out_q.delete();
    push(24'h080808, 1'b1, 1'b0, 2'd3);
    push(24'h080808, 1'b0, 1'b0, 2'd3);
    push(24'h080808, 1'b0, 1'b1, 2'd3);
    push(24'h080808, 1'b0, 1'b0, 2'd3);
    wait_out(4);
    exp_q = '{14'h2000, 14'h0111, 14'h1000, 14'h0000};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL diffuse_%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 14'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] tbl[10];
    int          cy[3];
    int          i, cyc;
    logic        acc;
    tbl = '{24'h080808, 24'h13F907, 24'h2FFF0B, 24'hF90180, 24'h070C13,
            24'h0B8001, 24'h80FF0C, 24'hFF0708, 24'h0113F9, 24'h0C2F2F};
    // Reference error-diffusion model, one line with sof first and eol last.
    exp_q.delete();
    cy = '{0, 0, 0};
    for (int b = 0; b < 10; b++) begin
      logic [11:0] q;
      for (int c = 0; c < 3; c++) begin
        int v;
        v = int'(tbl[b][c*8 +: 8]) + ((b == 0) ? 0 : cy[c]);
        if (v > 255) v = 255;
        q[c*4 +: 4] = 4'(v / 16);
        cy[c] = (b == 9) ? 0 : v % 16;
      end
      exp_q.push_back({(b == 0), (b == 9), q});
    end
    out_q.delete();
    i = 0;
    cyc = 0;
    s_valid = 1'b1;
    mode = 2'd3;
    while (i < 10 && cyc < 200) begin
      s_data  = tbl[i];
      s_sof   = (i == 0);
      s_eol   = (i == 9);
      m_ready = (cyc >= 5);
      @(negedge clk);
      acc = s_ready;
      if (cyc >= 2 && cyc < 5) begin
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_cyc%0d: got %b want 0", cyc, s_ready); end
      end
      if (cyc == 5) begin
        checks++;
        if (i != 2) begin errors++; $display("FAIL bp_held: accepted %0d beats during stall want 2", i); end
      end
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    m_ready = 1'b1;
    wait_out(10);
    checks++;
    if (out_q.size() != 10) begin errors++; $display("FAIL bp_count: got %0d beats want 10", out_q.size()); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_beat_%0d: got %h want %h", k, (k < out_q.size()) ? out_q[k] : 14'h0, exp_q[k]);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    mode    = 2'd0;
    s_valid = 1'b0;
    s_data  = '0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_round();
    test_bayer();
    test_diffusion();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
